// File: rtl/game_pkg.sv
// Shared game types and constants.
//   state_e         : round state machine encoding
//   HEALTH_W/DMG_W  : health and damage widths
//   FULL_HEALTH_DEFAULT : default full-health load value
//   P1/P2           : player index constants (also round-robin pointer values)
//   sat_sub         : saturating health minus damage
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIGHT    = 2'd1,
    ST_KO_DRAIN = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam int unsigned HEALTH_W            = 9;
  localparam int unsigned DMG_W               = 8;
  localparam int unsigned FULL_HEALTH_DEFAULT = 200;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  // Clamp to zero when damage meets or exceeds remaining health.
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] health,
                                                  input logic [DMG_W-1:0]    dmg);
    logic [HEALTH_W-1:0] dmg_ext;
    dmg_ext = HEALTH_W'(dmg);
    return (dmg_ext >= health) ? '0 : (health - dmg_ext);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a registered single-cycle pulse every DIV clocks.
//   clk   : system clock
//   reset : synchronous active-high reset, restarts the count
//   tick  : one-cycle pulse, first one DIV cycles after reset release
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             at_top;

  assign at_top = (cnt_q == CNT_W'(DIV - 1));

  // Counter wraps 0..DIV-1; pulse is the registered wrap indication.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= at_top;
      cnt_q <= at_top ? '0 : (cnt_q + CNT_W'(1));
    end
  end

endmodule

// File: rtl/health_manager.sv
// Owns both fighters' health, arbitrates hit requests, applies saturating
// damage one hit per cycle, generates the bar animation tick and runs the
// round state machine (IDLE, FIGHT, KO_DRAIN, DONE).
//   clk, reset        : clock, synchronous active-high reset
//   round_start       : starts a round from IDLE or DONE
//   hit_req[1:0]      : bit0 P1 hits P2, bit1 P2 hits P1; held until acked
//   dmg_p1, dmg_p2    : damage carried by each player's hit
//   hit_ack[1:0]      : one-cycle grant pulse
//   p1_health, p2_health : current health values
//   drop_tick         : animation pulse every DROP_DIV cycles
//   ko[1:0]           : sticky KO flags (bit0 P1, bit1 P2)
//   fighting, round_done : state indications
module health_manager
  import game_pkg::*;
#(
  parameter int unsigned FULL_HEALTH   = FULL_HEALTH_DEFAULT,
  parameter int unsigned DROP_DIV      = 250000,
  parameter int unsigned KO_HOLD_TICKS = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                round_start,
  input  logic [1:0]          hit_req,
  input  logic [DMG_W-1:0]    dmg_p1,
  input  logic [DMG_W-1:0]    dmg_p2,
  output logic [1:0]          hit_ack,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                drop_tick,
  output logic [1:0]          ko,
  output logic                fighting,
  output logic                round_done
);

  localparam int unsigned KO_CNT_W = (KO_HOLD_TICKS > 1) ? $clog2(KO_HOLD_TICKS) : 1;

  state_e               state_q, state_d;
  logic                 rr_q;
  logic [KO_CNT_W-1:0]  ko_cnt_q;
  logic [1:0]           grant_c;
  logic                 dual_c;
  logic                 apply_c;
  logic                 reload_c;
  logic                 ko_hit_c;
  logic                 drain_end_c;
  logic [HEALTH_W-1:0]  p1_next_c, p2_next_c;

  tick_divider #(
    .DIV (DROP_DIV)
  ) u_drop_div (
    .clk   (clk),
    .reset (reset),
    .tick  (drop_tick)
  );

  // Arbiter: single requester wins outright, dual requests go to the RR pointer.
  always_comb begin
    grant_c = 2'b00;
    dual_c  = 1'b0;
    case (hit_req)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11: begin
        dual_c  = 1'b1;
        grant_c = (rr_q == P1) ? 2'b01 : 2'b10;
      end
      default: grant_c = 2'b00;
    endcase
  end

  // Damage datapath: P1's hit lands on P2 and vice versa.
  always_comb begin
    p2_next_c   = sat_sub(p2_health, dmg_p1);
    p1_next_c   = sat_sub(p1_health, dmg_p2);
    apply_c     = (state_q == ST_FIGHT);
    ko_hit_c    = apply_c && ((grant_c[0] && (p2_next_c == '0)) ||
                              (grant_c[1] && (p1_next_c == '0)));
    drain_end_c = drop_tick && (ko_cnt_q == KO_CNT_W'(KO_HOLD_TICKS - 1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; reload_c marks a round (re)start.
  always_comb begin
    state_d  = state_q;
    reload_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (round_start) begin
          state_d  = ST_FIGHT;
          reload_c = 1'b1;
        end
      end
      ST_FIGHT: begin
        if (ko_hit_c) state_d = ST_KO_DRAIN;
      end
      ST_KO_DRAIN: begin
        if (drain_end_c) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    fighting   = 1'b0;
    round_done = 1'b0;
    case (state_q)
      ST_FIGHT: fighting   = 1'b1;
      ST_DONE:  round_done = 1'b1;
      default: begin
        fighting   = 1'b0;
        round_done = 1'b0;
      end
    endcase
  end

  // Health, KO flags, acks and pointer. Reload beats any same-cycle hit,
  // which is still acked so the requester is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_health <= HEALTH_W'(FULL_HEALTH);
      p2_health <= HEALTH_W'(FULL_HEALTH);
      hit_ack   <= 2'b00;
      ko        <= 2'b00;
      rr_q      <= P1;
    end else begin
      hit_ack <= grant_c;
      if (reload_c) begin
        p1_health <= HEALTH_W'(FULL_HEALTH);
        p2_health <= HEALTH_W'(FULL_HEALTH);
        ko        <= 2'b00;
        rr_q      <= P1;
      end else begin
        if (dual_c) rr_q <= (rr_q == P1) ? P2 : P1;
        if (apply_c && grant_c[0]) begin
          p2_health <= p2_next_c;
          if (p2_next_c == '0) ko[1] <= 1'b1;
        end
        if (apply_c && grant_c[1]) begin
          p1_health <= p1_next_c;
          if (p1_next_c == '0) ko[0] <= 1'b1;
        end
      end
    end
  end

  // Counts animation pulses while the KO bar drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      ko_cnt_q <= '0;
    end else if (state_q != ST_KO_DRAIN) begin
      ko_cnt_q <= '0;
    end else if (drop_tick) begin
      ko_cnt_q <= drain_end_c ? '0 : (ko_cnt_q + KO_CNT_W'(1));
    end
  end

endmodule
